boundary_row_feeder: RTL
========================

# boundary_row_feeder

Upstream stage of the river renderer. Buffers river-boundary rows written by software over Avalon in a small FIFO. Releases exactly one row per video frame, at vertical-blank entry, as a data word plus a one-cycle shift pulse for the boundary line memory. This decouples CPU write timing from frame timing, so scrolling is smooth and tear-free.

## Interface

**Parameters**
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `BW`, 10: width of one boundary coordinate.
- `VSTART`, 480: `vcount` value that marks vertical-blank entry.

**Ports** (one clock; reset is asynchronous and active-low)
- `clk`  in  1: 50 MHz system clock.
- `reset_n`  in  1: asynchronous active-low reset.
- `chipselect`  in  1: Avalon select.
- `write`  in  1: Avalon write strobe.
- `read`  in  1: Avalon read strobe.
- `address`  in  3: register index.
- `writedata`  in  16: write data.
- `readdata`  out  16: registered read data.
- `vcount`  in  10: current scanline from the VGA counters.
- `row_data`  out  4*BW: `{b1,b2,b3,b4}` row for the boundary memory.
- `row_shift`  out  1: one-cycle pulse; the memory shifts `row_data` in.
- `fifo_full`  out  1: FIFO holds `DEPTH` rows.

## Operation

**Register map** (write when `chipselect && write`):
- Addr 0–3: stage `b1`..`b4` ← `writedata[BW-1:0]`.
- Addr 4: commit. Pushes the staged `{b1,b2,b3,b4}` into the FIFO. Staging registers keep their values.
- Addr 6: clear. Clears the sticky `overflow` flag and the `underrun` counter. `writedata` is ignored.
- Addr 5, 7: writes are ignored.

**Read** (`chipselect && read`), addr 5 returns `{overflow, 2'b0, underrun[7:0], count[4:0]}`. `count` is zero-extended or truncated to 5 bits. Any other address reads 0.

**Frame tick**
- Register `vcount_d`.
- `tick = (vcount == VSTART) && (vcount_d != VSTART)`, which fires once per frame.

**Pop**
- On `tick` with FIFO not empty: pop the head row.
- On `tick` with FIFO empty: no pop, no shift. `underrun` increments, saturating at 255.

**Push**
- Commit with FIFO not full: the row is written at the tail.
- Commit with FIFO full and no pop in the same cycle: the row is dropped and `overflow` is set (sticky).
- Commit and pop in the same cycle: the pop happens first, so the commit is always accepted and `count` is unchanged.

**Pointers and count**
- Read and write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
- `count` is `log2(DEPTH)+1` bits and ranges 0..DEPTH.
- `fifo_full = (count == DEPTH)`.

**Reset values**
- All outputs are 0: `readdata`, `row_data`, `row_shift`, `fifo_full`.
- Internal state is also 0: staging registers, pointers, `count`, `overflow`, `underrun`, `vcount_d`.
- FIFO storage contents are don't-care.
- Assertion mid-frame discards all queued rows immediately. No pulse is emitted until the first tick after deassertion.

## Timing

- `tick` is combinational in cycle T. The FIFO read happens at the edge ending T. `row_data` and `row_shift=1` are valid in cycle T+1, and `row_shift` returns to 0 in T+2.
- `row_data` holds its value between pulses.
- Commit at edge E: the row is poppable from cycle E+1. A tick in the same cycle as the commit into an empty FIFO does not see that row; it counts as an underrun.
- `readdata` is valid one cycle after the read strobe and holds until the next read.
- Status read in the same cycle as a state change returns the pre-edge value.
- There is at most one `row_shift` per frame, because ticks are ≥525 lines apart.

## Configuration

- `ROW_HOLD_EN`
  - Defined: a tick on an empty FIFO re-emits the last popped row (the current `row_data`) with `row_shift=1`, and `underrun` still increments. The river keeps scrolling by repeating terrain.
  - Undefined: a tick on an empty FIFO produces no pulse, and the river freezes.

## Test plan

- **Basic release:** reset, stage 100/300/0/0, commit, sweep `vcount` 479→480 → one cycle later `row_data={100,300,0,0}`, `row_shift` high exactly 1 cycle; `count` 1→0.
- **Order and overflow:** commit 17 distinct rows with DEPTH=16 → `fifo_full=1`, `overflow=1`, `count=16`. Over 16 frames, rows 1–16 emerge in order and row 17 never appears.
- **Underrun:** 3 ticks on an empty FIFO → no `row_shift`, status `underrun=3`. With `ROW_HOLD_EN`, three pulses carry the last row. Addr-6 write → `underrun=0`, `overflow=0`.
- **Simultaneous events:** FIFO full, commit on the tick cycle → the pop is emitted, the new row is accepted, `count` stays 16, `overflow` stays 0.
- **Frame-tick edge:** hold `vcount=480` for 1600 cycles → exactly one pulse. A one-cycle glitch 480→479→480 → two pulses; the bench checks edge semantics.
- **Async reset:** assert `reset_n=0` mid-frame with 5 rows queued and no clock edge → all outputs 0 immediately. After release, the next tick underruns.

Source files
------------

// File: rtl/boundary_row_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : boundary_row_feeder
//  Description : Avalon-written FIFO of river-boundary rows. Releases one
//                row per video frame at vertical-blank entry as a data word
//                plus a one-cycle shift pulse for the boundary line memory.
//                Optional macro ROW_HOLD_EN: on an empty-FIFO tick, re-emit
//                the last released row instead of freezing.
//  Revision    : 1.0 - initial release
// ============================================================================
module boundary_row_feeder #(
    parameter int DEPTH  = 16,
    parameter int BW     = 10,
    parameter int VSTART = 480
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            chipselect,
    input  logic            write,
    input  logic            read,
    input  logic [2:0]      address,
    input  logic [15:0]     writedata,
    output logic [15:0]     readdata,
    input  logic [9:0]      vcount,
    output logic [4*BW-1:0] row_data,
    output logic            row_shift,
    output logic            fifo_full
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [9:0]    VSTART_V = 10'(VSTART);

    // Staging registers, FIFO storage and queue bookkeeping
    logic [BW-1:0]   stage_q [4];
    logic [4*BW-1:0] mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      underrun_q, underrun_d;
    logic [9:0]      vcount_q;
    logic [15:0]     readdata_q;
    logic [4*BW-1:0] row_data_q;
    logic            row_shift_q;

    logic            w_tick, w_empty, w_full;
    logic            w_commit, w_clear, w_pop, w_push;
    logic [4:0]      w_count5;
    logic [15:0]     w_status;
    logic            w_unused;

    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == FULL_CNT);
    // Rising into the blanking line: holding vcount at VSTART fires only once
    assign w_tick   = (vcount == VSTART_V) && (vcount_q != VSTART_V);
    assign w_commit = chipselect && write && (address == 3'd4);
    assign w_clear  = chipselect && write && (address == 3'd6);
    assign w_pop    = w_tick && !w_empty;
    // A pop in the same cycle frees a slot, so a commit is then always taken
    assign w_push   = w_commit && (!w_full || w_pop);

    // Status count field is a fixed 5 bits regardless of DEPTH
    if (CW >= 5) begin : g_cnt_trunc
        assign w_count5 = count_q[4:0];
    end else begin : g_cnt_ext
        assign w_count5 = {{(5 - CW){1'b0}}, count_q};
    end

    assign w_status = {overflow_q, 2'b00, underrun_q, w_count5};
    assign w_unused = ^{writedata, count_q};

    // Next-state for pointers, occupancy and sticky status
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        underrun_d = underrun_q;
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CW'(1);
        end
        if (w_commit && !w_push) begin
            overflow_d = 1'b1;
        end
        if (w_tick && w_empty && (underrun_q != 8'hFF)) begin
            underrun_d = underrun_q + 8'd1;
        end
        // Software clear takes priority over a coincident set/increment
        if (w_clear) begin
            overflow_d = 1'b0;
            underrun_d = 8'd0;
        end
    end

    // Queue state, frame-edge history and staging registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 8'd0;
            vcount_q   <= 10'd0;
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            vcount_q   <= vcount;
            if (chipselect && write && !address[2]) begin
                stage_q[address[1:0]] <= writedata[BW-1:0];
            end
        end
    end

    // FIFO storage: contents need no reset, validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {stage_q[0], stage_q[1], stage_q[2], stage_q[3]};
        end
    end

    // Row output: data plus one-cycle shift pulse per frame tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_data_q  <= '0;
            row_shift_q <= 1'b0;
        end else begin
            row_shift_q <= 1'b0;
            if (w_pop) begin
                row_data_q  <= mem_q[rd_ptr_q];
                row_shift_q <= 1'b1;
            end
`ifdef ROW_HOLD_EN
            else if (w_tick) begin
                // Repeat the held row so the river keeps scrolling
                row_shift_q <= 1'b1;
            end
`endif
        end
    end

    // Registered Avalon read data, held until the next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= 16'd0;
        end else if (chipselect && read) begin
            readdata_q <= (address == 3'd5) ? w_status : 16'd0;
        end
    end

    assign readdata  = readdata_q;
    assign row_data  = row_data_q;
    assign row_shift = row_shift_q;
    assign fifo_full = w_full;

endmodule
`default_nettype wire
